// File: rtl/ysyx_24100012_inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and PC redirect.
// The master side is the fetch unit; the slave side is the memory, decode and branch-resolution logic.
interface ysyx_24100012_inst_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;
  logic                  imem_resp_err;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic                  inst_fault;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_valid, instruction, inst_pc, inst_fault,
    input  inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_valid, instruction, inst_pc, inst_fault,
    output inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_24100012_inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and hands the
// returned word plus its PC to decode; redirects replace the PC and squash in-flight responses.
module ysyx_24100012_inst_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input logic                       clk,
  input logic                       rst_n,
  ysyx_24100012_inst_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  flush_q, flush_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  fault_q, fault_d;

  logic                  req_fire;
  logic                  out_fire;
  logic [DATA_WIDTH-1:0] redir_pc;

  assign req_fire = (state_q == S_REQ) && bus.imem_req_ready;
  assign out_fire = (state_q == S_OUT) && bus.inst_ready;
  assign redir_pc = bus.redirect_pc & ALIGN_MASK;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = flush_q;
    instr_d   = instr_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (bus.redirect_valid) pc_d = redir_pc;
      end

      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          // Request already accepted for the old PC: its response must be dropped.
          if (req_fire) flush_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          if (flush_q || bus.redirect_valid) begin
            flush_d = 1'b0;
            state_d = S_REQ;
            if (bus.redirect_valid) pc_d = redir_pc;
          end else begin
            instr_d   = bus.imem_resp_err ? '0 : bus.imem_resp_data;
            inst_pc_d = pc_q;
            fault_d   = bus.imem_resp_err;
            state_d   = S_OUT;
          end
        end else if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          flush_d = 1'b1;
        end
      end

      S_OUT: begin
        // A redirect always leaves OUT; if decode took the word this cycle it keeps it.
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (out_fire) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      flush_q   <= 1'b0;
      instr_q   <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flush_q   <= flush_d;
      instr_q   <= instr_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_OUT);
  assign bus.instruction    = instr_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_fault     = fault_q;

endmodule
